// File: rtl/mul_seq_ctrl.sv
// Shift-and-add 8x8 unsigned multiply sequencer.
// Borrows the execution block's adder for each partial sum.
module mul_seq_ctrl #(
  parameter int          N_BITS  = 8,
  parameter logic [4:0]  OP_ADD  = 5'b00000,
  parameter logic [4:0]  OP_HOLD = 5'b10000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [N_BITS-1:0]   mcand,
  input  logic [N_BITS-1:0]   mplier,
  output logic [N_BITS-1:0]   ex_A,
  output logic [N_BITS-1:0]   ex_B,
  output logic [4:0]          ex_op,
  input  logic [N_BITS-1:0]   ex_ans,
  input  logic [3:0]          ex_flag,
  output logic                busy,
  output logic                done,
  output logic [2*N_BITS-1:0] product,
  output logic                prod_zero
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ADD,
    S_SUM,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [N_BITS-1:0]   hi_q, hi_d;
  logic [N_BITS-1:0]   lo_q, lo_d;
  logic [N_BITS-1:0]   mc_q, mc_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                c_q, c_d;
  logic [2*N_BITS-1:0] prod_q, prod_d;
  logic                pz_q, pz_d;
  logic [N_BITS-1:0]   exa_q, exa_d;
  logic [N_BITS-1:0]   exb_q, exb_d;

  // Only the carry flag matters here.
  logic unused_flags;
  assign unused_flags = ^ex_flag[3:1];

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mc_q    <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      prod_q  <= '0;
      pz_q    <= 1'b0;
      exa_q   <= '0;
      exb_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mc_q    <= mc_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      prod_q  <= prod_d;
      pz_q    <= pz_d;
      exa_q   <= exa_d;
      exb_q   <= exb_d;
    end
  end

  // Next-state, shift and iteration control.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mc_d    = mc_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    prod_d  = prod_q;
    pz_d    = pz_q;
    exa_d   = exa_q;
    exb_d   = exb_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          lo_d    = mplier;
          mc_d    = mcand;
          hi_d    = '0;
          cnt_d   = '0;
          c_d     = 1'b0;
          prod_d  = '0;
          pz_d    = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (lo_q[0]) begin
          exa_d   = hi_q;
          exb_d   = mc_q;
          state_d = S_ADD;
        end else begin
          hi_d    = {1'b0, hi_q[N_BITS-1:1]};
          lo_d    = {hi_q[0], lo_q[N_BITS-1:1]};
          cnt_d   = cnt_q + 4'd1;
          state_d = (cnt_q == 4'd7) ? S_DONE
                                    : S_CHECK;
        end
      end
      S_ADD: begin
        c_d     = ex_flag[0];
        state_d = S_SUM;
      end
      S_SUM: begin
        hi_d    = {c_q, ex_ans[N_BITS-1:1]};
        lo_d    = {ex_ans[0], lo_q[N_BITS-1:1]};
        cnt_d   = cnt_q + 4'd1;
        state_d = (cnt_q == 4'd7) ? S_DONE
                                  : S_CHECK;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Publish the product on entry to DONE so it is valid with done.
    if (state_d == S_DONE && state_q != S_DONE) begin
      prod_d = {hi_d, lo_d};
      pz_d   = ({hi_d, lo_d} == '0);
    end
  end

  assign ex_A      = exa_q;
  assign ex_B      = exb_q;
  assign ex_op     = (state_q == S_ADD) ? OP_ADD
                                        : OP_HOLD;
  assign busy      = (state_q == S_CHECK) ||
                     (state_q == S_ADD)   ||
                     (state_q == S_SUM);
  assign done      = (state_q == S_DONE);
  assign product   = prod_q;
  assign prod_zero = pz_q;

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle unsigned 8x8 multiply sequencer. Produces a 16-bit product by shift-and-add.
- Owns no adder. Each partial-sum addition is issued to the existing execution block's add path (op_dec ADD); the controller only does the shifting and iteration counting.
- Sits between the decode stage and the execution block. While busy it steers the execution block's A/B/op_dec inputs.

Parameters:
- N_BITS, 8, operand width; product is 2*N_BITS. Only 8 is supported.
- OP_ADD, 5'b00000, op_dec code issued for a partial-sum add.
- OP_HOLD, 5'b10000, op_dec code driven when no add is issued (execution block holds ans_ex, flags 0).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- mcand  input  8  multiplicand, captured on accepted start.
- mplier  input  8  multiplier, captured on accepted start.
- ex_A  output  8  to execution block A.
- ex_B  output  8  to execution block B.
- ex_op  output  5  to execution block op_dec.
- ex_ans  input  8  registered result from execution block (ans_ex).
- ex_flag  input  4  execution block flags {parity,overflow,zero,carry}; only bit 0 (carry) is used.
- busy  output  1  high from the cycle after an accepted start through the last iteration.
- done  output  1  one-cycle pulse when the product is valid.
- product  output  16  result, held until the next accepted start.
- prod_zero  output  1  product==0, valid with done, held with product.

Behaviour:
- Reset (synchronous, active-high, wins over everything): state=IDLE, busy=0, done=0, product=0, prod_zero=0, internal hi/lo/mcand/count/carry=0, ex_A=0, ex_B=0, ex_op=OP_HOLD.
- Reset asserted mid-operation aborts the multiply. No done pulse is generated.
- Registers: hi[7:0], lo[7:0], mc[7:0], cnt[3:0], c_reg.
- States: IDLE, CHECK, ADD, SUM, DONE.
- IDLE: on start=1, load lo=mplier, mc=mcand, hi=0, cnt=0, clear product and prod_zero, go to CHECK. start=0 stays IDLE.
- CHECK:
  - If lo[0]=0: {hi,lo} <= {1'b0,hi,lo}>>1; cnt+1; go to DONE if cnt==7, else CHECK.
  - If lo[0]=1: go to ADD.
- ADD:
  - Drive ex_A=hi, ex_B=mc, ex_op=OP_ADD for exactly this cycle.
  - The add carry is combinational in the same cycle, so c_reg <= ex_flag[0] at this edge.
  - Go to SUM.
- SUM:
  - ex_ans now holds hi+mc.
  - {hi,lo} <= {c_reg,ex_ans,lo}>>1; cnt+1; go to DONE if cnt==7, else CHECK.
- DONE:
  - product <= {hi,lo}, prod_zero <= ({hi,lo}==0), done=1 for this single cycle, busy=0.
  - Next state IDLE.
  - A start in DONE is ignored; it must be re-asserted in IDLE.
- Outside ADD: ex_op=OP_HOLD; ex_A and ex_B keep their last values.
- start while busy or in DONE is ignored, with no queuing.
- Latency: start sampled at edge 0 → DONE cycle = 9 + 2*popcount(mplier). Range is 9 to 25 cycles.
- busy is high in CHECK/ADD/SUM; done is high in DONE only; they are never both high.
- Arithmetic is unsigned. Carry out of the 8-bit add is never lost: it enters hi[7] on the shift.
- cnt is 4 bits, cannot wrap (max 8), and cnt==8 is never reached in CHECK.

Test Plan:
- Reset during SUM of 0xFF*0xFF → next cycle: state IDLE, busy=0, product=0, ex_op=OP_HOLD, no done pulse ever.
- start, mcand=0x37, mplier=0x00 → done exactly 9 cycles after start; product=0x0000; prod_zero=1; ex_op never equals OP_ADD.
- mcand=0xFF, mplier=0xFF → eight ADD cycles with ex_B=0xFF; done at cycle 25; product=0xFE01; prod_zero=0; carry path exercised.
- mcand=0x0C, mplier=0x0A → two adds; done at cycle 13; product=0x0078.
- start held high continuously with mcand=0x02, mplier=0x03 → exactly one multiply per IDLE visit; product=0x0006; busy low only in DONE/IDLE; operand changes while busy have no effect.
- Back-to-back: after 0x10*0x10 (product=0x0100), start in the IDLE cycle following DONE with 0x81*0x02 → product cleared on accept, then 0x0102; the first product is held until the second start.
